// File: rtl/opb_snapshot_regbank_ctrl.sv
// OPB slave that latches N_WORDS user words together on user_valid once armed.
// Ack is a one-cycle pulse one clock after select; writes commit in the ack cycle.
module opb_snapshot_regbank_ctrl #(
  parameter logic [31:0] C_BASEADDR   = 32'h01100000,
  parameter logic [31:0] C_HIGHADDR   = 32'h011000FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          N_WORDS      = 4
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  output logic                    Sl_xferAck,
  input  logic [32*N_WORDS-1:0]   user_data_in,
  input  logic                    user_valid,
  output logic                    armed
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr, off, wdata, rdata, capcnt_q;
  logic [29:0] word;
  logic        hit, wr_en, ctrl_wr, arm_wr, clr_wr, capture, data_rd;
  logic        cont_q, done_q;
  logic [7:0]  overrun_q;
  logic [31:0] data_q [N_WORDS];
  logic        unused_ok;

  // Bus bit 31-n is register bit n, so a plain vector copy keeps numeric value.
  assign addr  = OPB_ABus;
  assign wdata = OPB_DBus;
  assign off   = addr - C_BASEADDR;
  assign word  = off[31:2];

  assign hit     = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign wr_en   = Sl_xferAck && hit && !OPB_RNW;
  assign ctrl_wr = wr_en && (word == 30'd0) && OPB_BE[3];
  assign arm_wr  = ctrl_wr && wdata[0];
  assign clr_wr  = ctrl_wr && wdata[1];
  assign data_rd = hit && OPB_RNW && (word >= 30'd16);
  // A same-cycle ARM or CLEAR takes precedence over the strobe.
  assign capture = (state_q == S_ARMED) && user_valid && !arm_wr && !clr_wr;

  assign armed      = (state_q == S_ARMED);
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;
  assign unused_ok  = ^{OPB_seqAddr, OPB_BE[0:2], wdata[31:3], off[1:0]};

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr_wr)                   state_d = S_IDLE;
    else if (arm_wr)              state_d = S_ARMED;
    else if (capture && !cont_q)  state_d = S_DONE;
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      Sl_xferAck <= 1'b0;
      cont_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 8'd0;
      capcnt_q   <= 32'd0;
      for (int i = 0; i < N_WORDS; i++) data_q[i] <= 32'd0;
    end else begin
      Sl_xferAck <= hit && !Sl_xferAck;
      if (ctrl_wr) cont_q <= wdata[2];
      if (clr_wr) begin
        done_q    <= 1'b0;
        overrun_q <= 8'd0;
        capcnt_q  <= 32'd0;
      end else if (capture) begin
        done_q   <= 1'b1;
        capcnt_q <= capcnt_q + 32'd1;
        if (data_rd && (overrun_q != 8'hFF)) overrun_q <= overrun_q + 8'd1;
        for (int i = 0; i < N_WORDS; i++) data_q[i] <= user_data_in[32*i +: 32];
      end
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (word)
      30'd0:   rdata = {29'd0, cont_q, 2'b00};
      30'd1:   rdata = {8'd0, 8'(N_WORDS), overrun_q, 6'd0, done_q, armed};
      30'd2:   rdata = capcnt_q;
      default: begin
        for (int i = 0; i < N_WORDS; i++)
          if (word == 30'(16 + i)) rdata = data_q[i];
      end
    endcase
  end

  assign Sl_DBus = (Sl_xferAck && OPB_RNW) ? rdata : '0;

endmodule
